// File: rtl/jpeg_dht_parser.sv
// jpeg_dht_parser: DHT segment payload -> Huffman symbol writes and per-length canonical code parameters.
// Optional table-content checks (totals, over-subscription) enabled by defining JPEG_DHT_CHECK_EN.
`default_nettype none

module jpeg_dht_parser (
  input  logic        rst,
  input  logic        clk,
  input  logic        Start,
  input  logic        DataInEnable,
  input  logic [7:0]  DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic        DhtEnable,
  output logic [1:0]  DhtColor,
  output logic [7:0]  DhtCount,
  output logic [7:0]  DhtData,
  output logic        CodeEnable,
  output logic [1:0]  CodeColor,
  output logic [3:0]  CodeLength,
  output logic [15:0] CodeStart,
  output logic [7:0]  CodeBase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN_H = 3'd1,
    S_LEN_L = 3'd2,
    S_TCTH  = 3'd3,
    S_BITS  = 3'd4,
    S_VALS  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_dht_en;
  logic        r_code_en;
  logic [1:0]  r_dht_color;
  logic [7:0]  r_dht_count;
  logic [7:0]  r_dht_data;
  logic [1:0]  r_code_color;
  logic [3:0]  r_code_len;
  logic [15:0] r_code_start;
  logic [7:0]  r_code_base;

  logic [7:0]  r_len_hi;
  logic [15:0] r_remain;
  logic        r_tc;
  logic        r_th;
  logic [16:0] r_code;
  logic [8:0]  r_total;
  logic [3:0]  r_lidx;
  logic [8:0]  r_vidx;

  logic        w_accept;
  logic        w_wr_code;
  logic        w_wr_dht;
  logic        w_done;
  logic [15:0] w_lh;
  logic [16:0] w_sum_code;
  logic [9:0]  w_sum_total;
  logic        w_last_seg;
  logic        w_tbl_end;
  logic        w_tcth_bad;
  logic        w_chk_err;
  logic        w_unused;

  // The byte presented alongside Start belongs to the previous context and is dropped.
  assign w_accept    = r_busy & DataInEnable & ~Start;
  assign w_lh        = {r_len_hi, DataIn};
  assign w_sum_code  = r_code + {9'd0, DataIn};
  assign w_sum_total = {1'b0, r_total} + {2'd0, DataIn};
  assign w_last_seg  = (r_remain == 16'd1);
  assign w_tcth_bad  = (DataIn[7:4] > 4'd1) || (DataIn[3:0] > 4'd1);
  assign w_unused    = ^{w_sum_code[16], w_sum_total[9]};

`ifdef JPEG_DHT_CHECK_EN
  logic [4:0]  w_lplus;
  logic [17:0] w_code_lim;
  logic [17:0] w_code_req;
  assign w_lplus    = {1'b0, r_lidx} + 5'd1;
  assign w_code_lim = 18'd1 << w_lplus;
  assign w_code_req = {1'b0, r_code} + {10'd0, DataIn};
  assign w_chk_err  = (w_sum_total > 10'd256) ||
                      (!r_tc && (w_sum_total > 10'd16)) ||
                      (w_code_req > w_code_lim);
`else
  assign w_chk_err  = 1'b0;
`endif

  always_comb begin
    w_tbl_end = 1'b0;
    if (r_state == S_BITS) begin
      w_tbl_end = (r_lidx == 4'd15) && (w_sum_total[8:0] == 9'd0);
    end else if (r_state == S_VALS) begin
      w_tbl_end = (r_vidx == (r_total - 9'd1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_code   = 1'b0;
    w_wr_dht    = 1'b0;
    w_done      = 1'b0;
    if (Start) begin
      w_state_nxt = S_LEN_H;
    end else if (w_accept) begin
      case (r_state)
        S_LEN_H: w_state_nxt = S_LEN_L;
        S_LEN_L: w_state_nxt = (w_lh < 16'd19) ? S_ERR : S_TCTH;
        S_TCTH:  w_state_nxt = (w_tcth_bad || w_last_seg) ? S_ERR : S_BITS;
        S_BITS: begin
          if (w_chk_err || (w_last_seg && !w_tbl_end)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wr_code = 1'b1;
            if (r_lidx == 4'd15) begin
              if (w_tbl_end) begin
                w_done      = w_last_seg;
                w_state_nxt = w_last_seg ? S_IDLE : S_TCTH;
              end else begin
                w_state_nxt = S_VALS;
              end
            end
          end
        end
        S_VALS: begin
          if (w_last_seg && !w_tbl_end) begin
            w_state_nxt = S_ERR;
          end else begin
            w_wr_dht = 1'b1;
            if (w_tbl_end) begin
              w_done      = w_last_seg;
              w_state_nxt = w_last_seg ? S_IDLE : S_TCTH;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_dht_en     <= 1'b0;
      r_code_en    <= 1'b0;
      r_dht_color  <= 2'd0;
      r_dht_count  <= 8'd0;
      r_dht_data   <= 8'd0;
      r_code_color <= 2'd0;
      r_code_len   <= 4'd0;
      r_code_start <= 16'd0;
      r_code_base  <= 8'd0;
      r_len_hi     <= 8'd0;
      r_remain     <= 16'd0;
      r_tc         <= 1'b0;
      r_th         <= 1'b0;
      r_code       <= 17'd0;
      r_total      <= 9'd0;
      r_lidx       <= 4'd0;
      r_vidx       <= 9'd0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
      r_error   <= (w_state_nxt == S_ERR);
      r_done    <= w_done;
      r_dht_en  <= w_wr_dht;
      r_code_en <= w_wr_code;

      if (w_wr_code) begin
        r_code_color <= {r_th, r_tc};
        r_code_len   <= r_lidx;
        r_code_start <= r_code[15:0];
        r_code_base  <= r_total[7:0];
      end
      if (w_wr_dht) begin
        r_dht_color <= {r_th, r_tc};
        r_dht_count <= r_vidx[7:0];
        r_dht_data  <= DataIn;
      end

      if (Start) begin
        r_len_hi <= 8'd0;
        r_remain <= 16'd0;
        r_code   <= 17'd0;
        r_total  <= 9'd0;
        r_lidx   <= 4'd0;
        r_vidx   <= 9'd0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN_H: r_len_hi <= DataIn;
          S_LEN_L: r_remain <= w_lh - 16'd2;
          S_TCTH: begin
            r_remain <= r_remain - 16'd1;
            r_tc     <= DataIn[4];
            r_th     <= DataIn[0];
            r_code   <= 17'd0;
            r_total  <= 9'd0;
            r_lidx   <= 4'd0;
            r_vidx   <= 9'd0;
          end
          S_BITS: begin
            r_remain <= r_remain - 16'd1;
            r_code   <= {w_sum_code[15:0], 1'b0};
            r_total  <= w_sum_total[8:0];
            r_lidx   <= r_lidx + 4'd1;
          end
          S_VALS: begin
            r_remain <= r_remain - 16'd1;
            r_vidx   <= r_vidx + 9'd1;
          end
          default: r_remain <= r_remain;
        endcase
      end
    end
  end

  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Error      = r_error;
  assign DhtEnable  = r_dht_en;
  assign DhtColor   = r_dht_color;
  assign DhtCount   = r_dht_count;
  assign DhtData    = r_dht_data;
  assign CodeEnable = r_code_en;
  assign CodeColor  = r_code_color;
  assign CodeLength = r_code_len;
  assign CodeStart  = r_code_start;
  assign CodeBase   = r_code_base;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_dht_parser.sv
// tb_jpeg_dht_parser: randomized DHT segments checked against a byte-position parsing model.
`default_nettype none

module tb_jpeg_dht_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start = 1'b0;
  logic        DataInEnable = 1'b0;
  logic [7:0]  DataIn = 8'd0;
  logic        Busy, Done, Error, DhtEnable, CodeEnable;
  logic [1:0]  DhtColor, CodeColor;
  logic [7:0]  DhtCount, DhtData, CodeBase;
  logic [3:0]  CodeLength;
  logic [15:0] CodeStart;

  jpeg_dht_parser dut (
    .rst(rst), .clk(clk), .Start(Start), .DataInEnable(DataInEnable), .DataIn(DataIn),
    .Busy(Busy), .Done(Done), .Error(Error),
    .DhtEnable(DhtEnable), .DhtColor(DhtColor), .DhtCount(DhtCount), .DhtData(DhtData),
    .CodeEnable(CodeEnable), .CodeColor(CodeColor), .CodeLength(CodeLength),
    .CodeStart(CodeStart), .CodeBase(CodeBase)
  );

  always #5 clk = ~clk;

`ifdef JPEG_DHT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_done = 0;
  byte unsigned seg[$];
  logic [29:0]  exp_code[$];
  logic [17:0]  exp_dht[$];
  bit           exp_err;
  bit           exp_done;
  int           ncons;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walks the segment by byte position; ncons = number of bytes the parser must accept.
  task automatic model();
    int lh, p, hi, lo, code, total, nt, n;
    bit last, tend;
    logic [1:0] col;
    exp_code.delete();
    exp_dht.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    lh = int'(seg[0]) * 256 + int'(seg[1]);
    if (lh < 19) begin exp_err = 1'b1; ncons = 2; return; end
    p = 2;
    forever begin
      hi = int'(seg[p]) / 16;
      lo = int'(seg[p]) % 16;
      if (hi > 1 || lo > 1 || p == lh - 1) begin exp_err = 1'b1; ncons = p + 1; return; end
      col = {lo[0], hi[0]};
      p++;
      code = 0;
      total = 0;
      for (int L = 1; L <= 16; L++) begin
        n    = int'(seg[p]);
        nt   = total + n;
        last = (p == lh - 1);
        tend = (L == 16) && ((nt % 512) == 0);
        if ((CHK && (nt > 256 || (hi == 0 && nt > 16) || code + n > (1 << L))) || (last && !tend)) begin
          exp_err = 1'b1; ncons = p + 1; return;
        end
        exp_code.push_back({col, 4'(L - 1), 16'(code), 8'(total)});
        total = nt % 512;
        code  = ((code + n) * 2) % 131072;
        p++;
      end
      for (int i = 0; i < total; i++) begin
        last = (p == lh - 1);
        if (last && i != total - 1) begin exp_err = 1'b1; ncons = p + 1; return; end
        exp_dht.push_back({col, 8'(i), seg[p]});
        p++;
      end
      if (p == lh) begin exp_done = 1'b1; ncons = p; return; end
    end
  endtask

  task automatic begin_seg();
    seg.delete();
    seg.push_back(8'd0);
    seg.push_back(8'd0);
  endtask

  task automatic add_table(input int tcth, input int bits[16], input bit seq_sym);
    int tot;
    tot = 0;
    seg.push_back(8'(tcth));
    for (int i = 0; i < 16; i++) begin seg.push_back(8'(bits[i])); tot += bits[i]; end
    for (int i = 0; i < tot; i++) seg.push_back(seq_sym ? 8'(i) : 8'($urandom));
  endtask

  task automatic add_rand_table(input int tcth, input int maxn);
    int b[16];
    for (int i = 0; i < 16; i++) b[i] = int'($urandom_range(0, maxn));
    add_table(tcth, b, 1'b0);
  endtask

  task automatic end_seg(input int delta);
    int lh;
    lh = seg.size() + delta;
    if (lh < 0) lh = 0;
    seg[0] = 8'(lh / 256);
    seg[1] = 8'(lh % 256);
    while (seg.size() < lh + 4) seg.push_back(8'($urandom));
  endtask

  task automatic send_seg(input int gapmode, input int abort_at);
    int g;
    model();
    n_done = 0;
    @(posedge clk); #1;
    Start = 1'b1;
    DataInEnable = 1'($urandom_range(0, 1));
    DataIn = 8'($urandom);
    @(posedge clk); #1;
    Start = 1'b0;
    DataInEnable = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
    chk("err_clear_on_start", 32'(Error), 32'd0);
    for (int k = 0; k < ncons + 2; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'({Busy, Done, Error, DhtEnable, CodeEnable}), 32'd0);
        chk("rst_dht", 32'({DhtColor, DhtCount, DhtData}), 32'd0);
        chk("rst_code", 32'({CodeColor, CodeLength, CodeStart, CodeBase}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_code.delete();
        exp_dht.delete();
        return;
      end
      g = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (g) begin
        DataInEnable = 1'b0;
        DataIn = 8'($urandom);
        @(posedge clk); #1;
        if (k < ncons) chk("busy_in_gap", 32'(Busy), 32'd1);
      end
      if (k < ncons) chk("busy_at_byte", 32'(Busy), 32'd1);
      DataInEnable = 1'b1;
      DataIn = (k < seg.size()) ? seg[k] : 8'($urandom);
      @(posedge clk); #1;
      DataInEnable = 1'b0;
      if (k == ncons - 1) begin
        chk("busy_fall", 32'(Busy), 32'd0);
        chk("error_after_last", 32'(Error), 32'(exp_err));
        chk("done_after_last", 32'(Done), 32'(exp_done));
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("end_error", 32'(Error), 32'(exp_err));
    chk("end_busy", 32'(Busy), 32'd0);
    chk("done_count", 32'(n_done), 32'(exp_done));
    chk("left_code_writes", 32'(exp_code.size()), 32'd0);
    chk("left_dht_writes", 32'(exp_dht.size()), 32'd0);
  endtask

  always @(negedge clk) begin : cmp_blk
    logic [29:0] ec;
    logic [17:0] ed;
    if (!rst) begin
      if (CodeEnable) begin
        if (exp_code.size() == 0) chk("unexpected_code_write", 32'd1, 32'd0);
        else begin
          ec = exp_code.pop_front();
          chk("code_write", 32'({CodeColor, CodeLength, CodeStart, CodeBase}), 32'(ec));
        end
      end
      if (DhtEnable) begin
        if (exp_dht.size() == 0) chk("unexpected_dht_write", 32'd1, 32'd0);
        else begin
          ed = exp_dht.pop_front();
          chk("dht_write", 32'({DhtColor, DhtCount, DhtData}), 32'(ed));
        end
      end
      if (Done) begin
        n_done++;
        chk("writes_done_at_done", 32'(exp_code.size() + exp_dht.size()), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ydc[16], b_cdc[16], b_cac[16], b_dc17[16], b_zero[16];
    int r, tcth, nt;
    b_ydc  = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    b_cdc  = '{0, 3, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    b_cac  = '{0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    b_dc17 = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    b_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({Busy, Done, Error, DhtEnable, CodeEnable}), 32'd0);
    chk("reset_dht", 32'({DhtColor, DhtCount, DhtData}), 32'd0);
    chk("reset_code", 32'({CodeColor, CodeLength, CodeStart, CodeBase}), 32'd0);
    rst = 1'b0;

    // Standard luminance DC table.
    begin_seg(); add_table(8'h00, b_ydc, 1'b1); end_seg(0);
    model();
    chk("pin_lh", 32'(seg[1]), 32'h1F);
    chk("pin_code_L1", 32'(exp_code[0]), 32'({2'b00, 4'd0, 16'd0, 8'd0}));
    chk("pin_code_L3", 32'(exp_code[2]), 32'({2'b00, 4'd2, 16'd2, 8'd1}));
    chk("pin_code_L4", 32'(exp_code[3]), 32'({2'b00, 4'd3, 16'd14, 8'd6}));
    chk("pin_n_dht", 32'(exp_dht.size()), 32'd12);
    chk("pin_done", 32'(exp_done), 32'd1);
    send_seg(0, -1);
    send_seg(1, -1);

    // Two chroma tables in one segment.
    begin_seg(); add_table(8'h01, b_cdc, 1'b1); add_table(8'h11, b_cac, 1'b1); end_seg(0);
    model();
    chk("pin_2tab_code", 32'(exp_code[16]), 32'({2'b11, 4'd0, 16'd0, 8'd0}));
    chk("pin_2tab_dht", 32'(exp_dht[12]), 32'({2'b11, 8'd0, 8'd0}));
    send_seg(2, -1);

    // Bad Tc/Th, then Lh too small, then a short Remain.
    begin_seg(); add_table(8'h20, b_zero, 1'b1); end_seg(0);
    model();
    chk("pin_tcth_ncons", 32'(ncons), 32'd3);
    send_seg(0, -1);
    begin_seg(); add_table(8'h00, b_zero, 1'b1); end_seg(18 - 19);
    send_seg(1, -1);
    begin_seg(); add_table(8'h00, b_ydc, 1'b1); end_seg(-4);
    send_seg(0, -1);
    // Empty table: Done on the last code write.
    begin_seg(); add_table(8'h10, b_zero, 1'b1); end_seg(0);
    send_seg(0, -1);

    // DC table with 17 symbols.
    begin_seg(); add_table(8'h00, b_dc17, 1'b1); end_seg(0);
    model();
    chk("pin_dc17", 32'(exp_dht.size()), CHK ? 32'd0 : 32'd17);
    send_seg(0, -1);

    // Reset in the middle of VALS, then a fresh segment.
    begin_seg(); add_table(8'h00, b_ydc, 1'b1); end_seg(0);
    send_seg(0, 24);
    send_seg(2, -1);

    for (int s = 0; s < 30; s++) begin
      begin_seg();
      nt = int'($urandom_range(1, 3));
      for (int t = 0; t < nt; t++) begin
        r = int'($urandom_range(0, 3));
        tcth = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 255)) : ((r / 2) * 16 + (r % 2));
        add_rand_table(tcth, (tcth / 16 == 0) ? 2 : 3);
      end
      r = int'($urandom_range(0, 9));
      if (r == 0) end_seg(-int'($urandom_range(1, 5)));
      else if (r == 1) end_seg(int'($urandom_range(1, 3)));
      else if (r == 2) end_seg(int'($urandom_range(0, 18)) - seg.size());
      else end_seg(0);
      send_seg(int'($urandom_range(0, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jpeg_dht_parser.md
# jpeg_dht_parser

Parses the payload of a JPEG DHT marker segment (bytes after FF C4) and turns it into table-write transactions. Symbol bytes (HUFFVAL) go to the downstream Huffman symbol RAM as DC/AC × Y/C indexed writes. Per-length canonical code parameters (first code, symbol base index) are emitted on a second write port for the Huffman decoder's compare logic. It sits between the marker/header scanner and the DHT symbol RAM.

## Interface
Parameters: none.
- rst  in  1  asynchronous, active-high reset
- clk  in  1  clock
- Start  in  1  one-cycle pulse: scanner has seen FF C4; next byte is Lh high
- DataInEnable  in  1  byte valid on DataIn
- DataIn  in  8  segment byte
- Busy  out  1  parser is consuming bytes (byte accepted whenever Busy & DataInEnable)
- Done  out  1  one-cycle pulse: segment fully parsed without error
- Error  out  1  sticky malformed-segment flag, cleared by Start
- DhtEnable  out  1  symbol write strobe
- DhtColor  out  2  {Th[0],Tc[0]}: 00 Ydc, 01 Yac, 10 Cdc, 11 Cac
- DhtCount  out  8  symbol index within table
- DhtData  out  8  symbol byte (run/size)
- CodeEnable  out  1  code-parameter write strobe
- CodeColor  out  2  same encoding as DhtColor
- CodeLength  out  4  code length minus 1 (0 = length 1)
- CodeStart  out  16  first canonical code of this length
- CodeBase  out  8  index of first symbol of this length

## Operation
- States: IDLE, LEN_H, LEN_L, TCTH, BITS, VALS, ERR.
- IDLE: Start → LEN_H; Error cleared. Bytes ignored.
- LEN_H/LEN_L: Remain[15:0] = Lh − 2. Lh < 19 → ERR.
- TCTH: latch Tc = DataIn[7:4], Th = DataIn[3:0]; clear code accumulator (17 bits), symbol total (9 bits), length index. Tc > 1 or Th > 1 → ERR.
- BITS: 16 bytes N[L], L = 1..16. Per byte, emit CodeEnable with CodeStart = code, CodeBase = total[7:0]; then total += N, code = (code + N) << 1.
- After L=16: total = 0 → skip VALS; else VALS for `total` bytes, each emitting DhtEnable with DhtCount = 0..total−1.
- End of table: Remain = 0 → pulse Done, IDLE; Remain > 0 → TCTH (multiple tables per segment).
- Every accepted byte decrements Remain; Remain reaching 0 before table end → ERR.
- ERR: Error = 1, Busy = 0, no writes; exits only on Start or rst.
- Start while Busy: restarts at LEN_H; Error cleared; no partial-state carry-over.

## Timing
- Reset: state IDLE; Busy, Done, Error, DhtEnable, CodeEnable = 0; all data outputs 0.
- Busy is registered: high from the cycle after Start until the cycle after the last byte or error.
- Byte on Start's cycle is not consumed.
- One byte per cycle max; gaps (DataInEnable = 0) stall without side effects.
- DhtEnable/CodeEnable: 1 cycle after accepting the byte, one cycle wide, with data/index/color valid the same cycle.
- Done: coincides with the final table's last write (or last BITS CodeEnable if total = 0), together with the Busy fall.
- Error: rises 1 cycle after the offending byte; no write is issued for that byte.

## Configuration
- JPEG_DHT_CHECK_EN defined: table-content checks active:
  - total > 256 → ERR
  - DC table (Tc = 0) total > 16 → ERR
  - over-subscribed length (code + N > 2^L before shift) → ERR
- Undefined: those three checks are omitted and writes proceed with wrapped counts. Lh, Tc/Th and Remain checks are always present.

## Test plan
- Std luminance DC, Lh = 0x001F, Tc/Th 0x00, BITS 0,1,5,1,1,1,1,1,1,0×7, symbols 0..11 → CodeStart/CodeBase L1 0/0, L2 0/0, L3 2/1, L4 14/6; 12 DhtEnable, color 00, count 0..11; Done once; Error 0.
- Two tables in one segment (Cdc 0x01 then Cac 0x11), Lh = sum → writes colors 10 then 11, DhtCount restarts at 0, single Done.
- DataInEnable toggled every other cycle → identical write sequence and values; Busy held throughout.
- Tc/Th byte 0x20 → Error 1 cycle later, no further writes, Busy 0; next Start clears Error.
- With JPEG_DHT_CHECK_EN, DC table BITS summing to 17 → Error, no DhtEnable; without the macro, 17 writes, Done.
- rst asserted mid-VALS → all outputs 0 immediately; after release, Start plus a fresh segment parses correctly.
